// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
// Holds the serializer state encodings and the frame-shape constants.
package uart_pkg;

    // Serializer states; PARITY is only visited when parity is enabled.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] i_data);
        return ^i_data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host-side write port and status/serial outputs of the
// buffered UART transmitter. The host uses the master modport, the
// transmitter the slave modport.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    logic                          i_Wr_En;
    logic [7:0]                    i_Wr_Byte;
    logic                          o_Full;
    logic                          o_Empty;
    logic [$clog2(FIFO_DEPTH):0]   o_Count;
    logic                          o_Overflow;
    logic                          o_Tx_Serial;
    logic                          o_Tx_Active;
    logic                          o_Tx_Done;

    modport master (
        output i_Wr_En, i_Wr_Byte,
        input  o_Full, o_Empty, o_Count, o_Overflow,
        input  o_Tx_Serial, o_Tx_Active, o_Tx_Done
    );

    modport slave (
        input  i_Wr_En, i_Wr_Byte,
        output o_Full, o_Empty, o_Count, o_Overflow,
        output o_Tx_Serial, o_Tx_Active, o_Tx_Done
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered occupancy count.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// A push while full is dropped and flagged with a one-cycle o_Overflow,
// even if a pop happens in the same cycle. The head entry is presented
// combinationally on o_Data.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Push,
    input  logic                     i_Pop,
    input  logic [WIDTH-1:0]         i_Data,
    output logic [WIDTH-1:0]         o_Data,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_Mem [DEPTH];
    logic [AW-1:0]    r_Wr_Ptr;
    logic [AW-1:0]    r_Rd_Ptr;
    logic [AW:0]      r_Count;
    logic             r_Overflow;

    logic             w_Push_Ok;
    logic             w_Pop_Ok;

    assign o_Full     = (r_Count == FULL_COUNT);
    assign o_Empty    = (r_Count == '0);
    assign o_Count    = r_Count;
    assign o_Overflow = r_Overflow;
    assign o_Data     = r_Mem[r_Rd_Ptr];

    assign w_Push_Ok  = i_Push && !o_Full;
    assign w_Pop_Ok   = i_Pop && !o_Empty;

    // Storage write: capture the incoming word at the write pointer.
    // NOTE: the storage array is deliberately not reset; an entry is only
    // read after it has been written, and an unreset array can map to RAM.
    always_ff @(posedge i_Clock) begin
        if (w_Push_Ok) begin
            r_Mem[r_Wr_Ptr] <= i_Data;
        end
    end

    // Pointer, occupancy and overflow bookkeeping.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Wr_Ptr   <= '0;
            r_Rd_Ptr   <= '0;
            r_Count    <= '0;
            r_Overflow <= 1'b0;
        end else begin
            if (w_Push_Ok) begin
                r_Wr_Ptr <= r_Wr_Ptr + AW'(1);
            end
            if (w_Pop_Ok) begin
                r_Rd_Ptr <= r_Rd_Ptr + AW'(1);
            end
            case ({w_Push_Ok, w_Pop_Ok})
                2'b10:   r_Count <= r_Count + (AW+1)'(1);
                2'b01:   r_Count <= r_Count - (AW+1)'(1);
                default: r_Count <= r_Count;
            endcase
            r_Overflow <= i_Push && o_Full;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter. A sync_fifo absorbs host bytes
// and a serializer drains it as 8N1 frames, back to back while data is
// queued. Optional build macro UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit (8E1).
//
// The IDLE cycle that pops the FIFO only loads the shift register; every
// state drives its line level on the following edge, so a write at edge N
// into an idle, empty transmitter drops the line at edge N+2.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic           i_Clock,
    input  logic           i_Reset,
    uart_tx_fifo_if.slave  bus
);
    import uart_pkg::*;

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

    uart_state_t             r_State;
    logic [CW-1:0]           r_Clk_Cnt;
    logic [2:0]              r_Bit_Idx;
    logic [DATA_BITS-1:0]    r_Shift;
    logic                    r_Tx_Serial;
    logic                    r_Tx_Active;
    logic                    r_Tx_Done;

    logic [DATA_BITS-1:0]           w_Head;
    logic                           w_Full;
    logic                           w_Empty;
    logic [$clog2(FIFO_DEPTH):0]    w_Count;
    logic                           w_Overflow;
    logic                           w_Bit_End;
    logic                           w_Pop;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Push     (bus.i_Wr_En),
        .i_Pop      (w_Pop),
        .i_Data     (bus.i_Wr_Byte),
        .o_Data     (w_Head),
        .o_Full     (w_Full),
        .o_Empty    (w_Empty),
        .o_Count    (w_Count),
        .o_Overflow (w_Overflow)
    );

    assign w_Bit_End = (r_Clk_Cnt == CNT_LAST);

    // A byte is taken from the FIFO either from IDLE or on the very last
    // stop-bit cycle, which is what makes consecutive frames gapless.
    assign w_Pop = !w_Empty && ((r_State == IDLE) || ((r_State == STOP) && w_Bit_End));

    assign bus.o_Full      = w_Full;
    assign bus.o_Empty     = w_Empty;
    assign bus.o_Count     = w_Count;
    assign bus.o_Overflow  = w_Overflow;
    assign bus.o_Tx_Serial = r_Tx_Serial;
    assign bus.o_Tx_Active = r_Tx_Active;
    assign bus.o_Tx_Done   = r_Tx_Done;

    // Serializer FSM with registered line, activity and done outputs.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State     <= IDLE;
            r_Clk_Cnt   <= '0;
            r_Bit_Idx   <= '0;
            r_Shift     <= '0;
            r_Tx_Serial <= 1'b1;
            r_Tx_Active <= 1'b0;
            r_Tx_Done   <= 1'b0;
        end else begin
            r_Tx_Done <= 1'b0;
            case (r_State)
                IDLE: begin
                    r_Tx_Serial <= 1'b1;
                    r_Tx_Active <= 1'b0;
                    r_Clk_Cnt   <= '0;
                    r_Bit_Idx   <= '0;
                    if (w_Pop) begin
                        r_Shift <= w_Head;
                        r_State <= START;
                    end
                end

                START: begin
                    r_Tx_Serial <= 1'b0;
                    r_Tx_Active <= 1'b1;
                    if (w_Bit_End) begin
                        r_Clk_Cnt <= '0;
                        r_State   <= DATA;
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + CW'(1);
                    end
                end

                DATA: begin
                    r_Tx_Serial <= r_Shift[r_Bit_Idx];
                    r_Tx_Active <= 1'b1;
                    if (w_Bit_End) begin
                        r_Clk_Cnt <= '0;
                        if (r_Bit_Idx == IDX_LAST) begin
                            r_Bit_Idx <= '0;
`ifdef UART_TX_PARITY_EN
                            r_State   <= PARITY;
`else
                            r_State   <= STOP;
`endif
                        end else begin
                            r_Bit_Idx <= r_Bit_Idx + 3'd1;
                        end
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + CW'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    r_Tx_Serial <= even_parity(r_Shift);
                    r_Tx_Active <= 1'b1;
                    if (w_Bit_End) begin
                        r_Clk_Cnt <= '0;
                        r_State   <= STOP;
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + CW'(1);
                    end
                end
`endif

                STOP: begin
                    r_Tx_Serial <= 1'b1;
                    r_Tx_Active <= 1'b1;
                    if (w_Bit_End) begin
                        r_Clk_Cnt <= '0;
                        r_Tx_Done <= 1'b1;
                        if (w_Pop) begin
                            r_Shift <= w_Head;
                            r_State <= START;
                        end else begin
                            r_State <= IDLE;
                        end
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + CW'(1);
                    end
                end

                default: begin
                    r_Tx_Serial <= 1'b1;
                    r_Tx_Active <= 1'b0;
                    r_Clk_Cnt   <= '0;
                    r_Bit_Idx   <= '0;
                    r_State     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo. A frame monitor
// acts as the receiving UART: it decodes every frame on the serial line and
// checks it against a queue of bytes pushed when the host writes them.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int CPB   = 87;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FL = FRAME_BITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus();

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    logic [7:0]  exp_q[$];
    int unsigned start_q[$];
    int unsigned done_q[$];
    int          frames_seen = 0;
    bit          mon_busy    = 1'b0;
    logic [7:0]  last_rx     = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Timestamp every o_Tx_Done pulse.
    always @(negedge clk) begin
        if (!rst && bus.o_Tx_Done === 1'b1) done_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned q_at(input int unsigned q[$], input int idx);
        return (idx < q.size()) ? q[idx] : 32'hFFFF_FFFF;
    endfunction

    // Drive one write strobe; returns at the negedge after the capturing edge.
    task automatic push(input logic [7:0] b, input bit accepted);
        bus.i_Wr_En   = 1'b1;
        bus.i_Wr_Byte = b;
        if (accepted) exp_q.push_back(b);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy || bus.o_Tx_Active !== 1'b0 || bus.o_Empty !== 1'b1)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", (n < budget), 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (bus.o_Tx_Done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_wait", (n < budget), 1);
    endtask

    // Frame monitor: every bit must hold for CPB cycles, the value is taken
    // mid-bit, o_Tx_Done must appear only on the last stop cycle and
    // o_Tx_Active must stay high for the whole frame.
    initial begin : monitor
        logic [FRAME_BITS-1:0] bits;
        logic                  first;
        bit                    aborted, ok_stable, ok_done, ok_active;
        logic [7:0]            exp_b;
        forever begin
            @(negedge clk);
            if (!rst && bus.o_Tx_Serial === 1'b0) begin
                mon_busy  = 1'b1;
                aborted   = 1'b0;
                ok_stable = 1'b1;
                ok_done   = 1'b1;
                ok_active = 1'b1;
                bits      = '0;
                first     = 1'b0;
                start_q.push_back(cyc);
                for (int k = 0; k < FRAME_BITS; k++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (k != 0 || c != 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c == 0) first = bus.o_Tx_Serial;
                        else if (bus.o_Tx_Serial !== first) ok_stable = 1'b0;
                        if (c == CPB / 2) bits[k] = bus.o_Tx_Serial;
                        if (bus.o_Tx_Done !== ((k == FRAME_BITS - 1) && (c == CPB - 1))) ok_done = 1'b0;
                        if (bus.o_Tx_Active !== 1'b1) ok_active = 1'b0;
                    end
                    if (aborted) break;
                end
                if (!aborted) begin
                    frames_seen++;
                    last_rx = bits[8:1];
                    check("frame_expected", (exp_q.size() != 0), 1);
                    exp_b = 8'hxx;
                    if (exp_q.size() != 0) exp_b = exp_q.pop_front();
                    check("rx_byte", bits[8:1], exp_b);
                    check("stop_bit", bits[FRAME_BITS-1], 1);
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", bits[9], ^exp_b);
`endif
                    check("bit_stable", ok_stable, 1);
                    check("done_pulse", ok_done, 1);
                    check("active_high", ok_active, 1);
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int unsigned t0;
        int          base_frames;
        int          base_done;
        int          n;
        bit          ovf_early;

        bus.i_Wr_En   = 1'b0;
        bus.i_Wr_Byte = 8'h00;
        rst           = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_serial",   bus.o_Tx_Serial, 1);
        check("rst_active",   bus.o_Tx_Active, 0);
        check("rst_done",     bus.o_Tx_Done,   0);
        check("rst_overflow", bus.o_Overflow,  0);
        check("rst_count",    bus.o_Count,     0);
        check("rst_empty",    bus.o_Empty,     1);
        check("rst_full",     bus.o_Full,      0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0xAB with latency checks.
        start_q.delete();
        done_q.delete();
        push(8'hAB, 1'b1);
        t0 = cyc;
        bus.i_Wr_En = 1'b0;
        check("lat_empty_fall", bus.o_Empty, 0);
        check("lat_count_one",  bus.o_Count, 1);
        @(negedge clk);
        check("lat_popped",     bus.o_Count, 0);
        check("lat_line_high",  bus.o_Tx_Serial, 1);
        @(negedge clk);
        check("lat_line_low",   bus.o_Tx_Serial, 0);
        wait_done(FL + 50);
        @(negedge clk);
        check("single_active_fall", bus.o_Tx_Active, 0);
        check("single_line_idle",   bus.o_Tx_Serial, 1);
        wait_idle(200);
        check("single_start_lat", q_at(start_q, 0) - t0, 2);
        check("single_done_off",  q_at(done_q, 0) - q_at(start_q, 0), FL - 1);

        // Burst of three bytes on consecutive cycles.
        start_q.delete();
        done_q.delete();
        push(8'h00, 1'b1);
        t0 = cyc;
        push(8'hFF, 1'b1);
        push(8'h55, 1'b1);
        bus.i_Wr_En = 1'b0;
        wait_idle(3 * FL + 200);
        check("burst_frames",  start_q.size(), 3);
        check("burst_lat",     q_at(start_q, 0) - t0, 2);
        check("burst_gap1",    q_at(start_q, 1) - q_at(start_q, 0), FL);
        check("burst_gap2",    q_at(start_q, 2) - q_at(start_q, 1), FL);
        check("burst_done1",   q_at(done_q, 0) - q_at(start_q, 0), FL - 1);
        check("burst_done2",   q_at(done_q, 1) - q_at(start_q, 0), 2 * FL - 1);
        check("burst_done3",   q_at(done_q, 2) - q_at(start_q, 0), 3 * FL - 1);

        // Overflow: 18 back-to-back writes into an empty FIFO.
        base_frames = frames_seen;
        ovf_early   = 1'b0;
        for (int i = 0; i < 18; i++) begin
            push(8'(i * 13 + 1), (i < 17));
            if (i < 17 && bus.o_Overflow !== 1'b0) ovf_early = 1'b1;
            if (i == 15) check("not_full_after_16", bus.o_Full, 0);
            if (i == 16) begin
                check("full_after_17",  bus.o_Full,  1);
                check("count_after_17", bus.o_Count, 16);
            end
            if (i == 17) begin
                check("overflow_pulse", bus.o_Overflow, 1);
                check("count_after_18", bus.o_Count,    16);
            end
        end
        bus.i_Wr_En = 1'b0;
        check("no_early_overflow", ovf_early, 0);
        @(negedge clk);
        check("overflow_single", bus.o_Overflow, 0);
        wait_idle(17 * FL + 500);
        check("overflow_frames", frames_seen - base_frames, 17);

        // Reset during data bit 3 of 0x3C with two bytes still queued.
        start_q.delete();
        push(8'h3C, 1'b1);
        push(8'hA1, 1'b1);
        push(8'hB2, 1'b1);
        bus.i_Wr_En = 1'b0;
        n = 0;
        while (start_q.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrst_start_seen", (n < 100), 1);
        repeat (CPB * 4 + 40) @(negedge clk);
        check("midrst_queued", bus.o_Count, 2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_line",   bus.o_Tx_Serial, 1);
        check("midrst_count",  bus.o_Count,     0);
        check("midrst_active", bus.o_Tx_Active, 0);
        check("midrst_empty",  bus.o_Empty,     1);
        rst = 1'b0;
        exp_q.delete();
        base_frames = frames_seen;
        base_done   = done_q.size();
        repeat (3 * FL) @(negedge clk);
        check("midrst_no_frames", frames_seen - base_frames, 0);
        check("midrst_no_done",   done_q.size() - base_done, 0);
        check("midrst_line_idle", bus.o_Tx_Serial, 1);

        // Loopback: the monitor plays the receiver.
        base_frames = frames_seen;
        push(8'h3F, 1'b1);
        bus.i_Wr_En = 1'b0;
        wait_idle(FL + 200);
        check("loop_valid", frames_seen - base_frames, 1);
        check("loop_byte",  last_rx, 8'h3F);

        // 0x07: parity bit (when built with parity) and frame length.
        start_q.delete();
        done_q.delete();
        push(8'h07, 1'b1);
        bus.i_Wr_En = 1'b0;
        wait_idle(FL + 200);
        check("frame_len", q_at(done_q, 0) - q_at(start_q, 0) + 1, FL);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: a synchronous FIFO accepts bytes from the host, and a serializer drains it onto the serial line as 8N1 frames.
- Frames are sent back-to-back with no idle gap while the FIFO holds data.
- Sits between a host/command engine and the TX pin.
- Complements the existing receiver for full-duplex links; it also relieves the host of per-byte handshaking.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per serial bit; must be >= 2 (10 MHz / 115200 baud).
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2, >= 2.

Ports:
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Wr_En  in  1  write strobe; one byte pushed per cycle high.
- i_Wr_Byte  in  8  byte to enqueue.
- o_Full  out  1  FIFO holds FIFO_DEPTH entries.
- o_Empty  out  1  FIFO holds 0 entries.
- o_Count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- o_Overflow  out  1  one-cycle pulse when a write is dropped.
- o_Tx_Serial  out  1  serial line; idle high.
- o_Tx_Active  out  1  high while any frame bit is driven.
- o_Tx_Done  out  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset values (next edge with i_Reset high): o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Overflow=0, o_Count=0, o_Empty=1, o_Full=0.
  - Pointers, bit counter and clock counter are cleared; state goes to IDLE.
- Reset mid-frame: the frame is aborted, the line is high on the next edge, and FIFO contents are discarded.
- FIFO:
  - Write while full: dropped, with an o_Overflow pulse. This applies even if a pop occurs in the same cycle.
  - Otherwise simultaneous push and pop leaves o_Count unchanged.
  - Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.
- State machine (IDLE, START, DATA, STOP):
  - IDLE: line high, o_Tx_Active=0. If !o_Empty, pop the head into the shift register and go to START.
  - START: line 0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles; a 3-bit index counts 0..7.
  - STOP: line 1 for CLKS_PER_BIT cycles. On the final cycle, pulse o_Tx_Done.
    - If the FIFO is non-empty on that cycle, pop and go directly to START. There is no idle cycle and o_Tx_Active stays high.
    - Otherwise go to IDLE.
- Latency:
  - A write on edge N into an empty FIFO with the transmitter idle makes o_Empty fall after edge N.
  - The pop happens at edge N+1, and o_Tx_Serial falls at edge N+2.
- Frame length: exactly 10*CLKS_PER_BIT cycles, start edge to next start edge, when sending back-to-back.
- Clock counter: $clog2(CLKS_PER_BIT) bits; counts 0..CLKS_PER_BIT-1, then resets to 0.
- Writes during an active frame never disturb the frame in flight.
- All outputs are registered except o_Full, o_Empty and o_Count, which decode the registered count.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting one bit of CLKS_PER_BIT cycles.
  - Even parity: the bit is the XOR of the 8 data bits.
  - Frame length is 11*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; the frame is 8N1 as above.

Decomposition:
- Package uart_pkg:
  - State encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3-bit).
  - Constants DATA_BITS=8 and STOP_BITS=1.
  - Shared with the receiver.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Register array with read/write pointers and a count.
  - Ports: push, pop, data, full, empty, count, overflow.
  - The top level holds the serializer FSM only.

Test Plan:
- Single byte: write 0xAB at edge N.
  - Line falls at N+2, then bits 0,1,1,0,1,0,1,0,1,1, each 87 cycles.
  - o_Tx_Done pulses on the last stop-bit cycle; o_Tx_Active falls after 870 cycles.
- Burst: write 0x00,0xFF,0x55 on 3 consecutive cycles.
  - Three contiguous frames totalling 2610 cycles, with no high gap between stop and start.
  - o_Tx_Done pulses at offsets 869, 1739 and 2609.
- Overflow: 18 consecutive writes into an empty FIFO.
  - The first is popped at once; o_Full is asserted after write 17 (o_Count=16).
  - Write 18 is dropped with a single o_Overflow pulse.
  - Exactly 17 frames follow, in order.
- Reset mid-frame: assert i_Reset during bit 3 of 0x3C with 2 bytes still queued.
  - Next edge: line high, o_Count=0, o_Tx_Active=0.
  - No further frames after release.
- Loopback: connect o_Tx_Serial to the receiver input and write 0x3F.
  - Receiver raises its data-valid flag with byte 0x3F.
- UART_TX_PARITY_EN defined: write 0x07.
  - Parity bit 1 after bit 7, then stop.
  - Frame length 957 cycles.
